// File: rtl/uart_pkg.sv
// Shared UART types and constants: receiver state encoding, oversample
// factor and the clocks-per-tick divisor table for a 100 MHz system clock.
package uart_pkg;

  localparam int CLK_HZ     = 100_000_000;
  localparam int OVERSAMPLE = 16;
  localparam int DIV_W      = 13;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_WAIT_HIGH
  } rx_state_t;

  // Rounded clocks per oversample tick for a given baud rate.
  function automatic logic [DIV_W-1:0] calc_div(input int rate);
    return DIV_W'((CLK_HZ + (OVERSAMPLE * rate) / 2) / (OVERSAMPLE * rate));
  endfunction

  // 1200, 2400, 4800, 9600, 19200, 38400, 57600, 115200 baud
  // -> 5208, 2604, 1302, 651, 326, 163, 109, 54 clocks per tick.
  localparam logic [DIV_W-1:0] BAUD_DIV [0:7] = '{
    calc_div(1200),  calc_div(2400),  calc_div(4800),  calc_div(9600),
    calc_div(19200), calc_div(38400), calc_div(57600), calc_div(115200)
  };

  function automatic logic [DIV_W-1:0] baud_div(input logic [2:0] sel);
    return BAUD_DIV[sel];
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Divisor counter producing a one-cycle tick every i_div clocks.
// i_clear restarts the count so the next tick lands exactly i_div clocks later.
module baud_tick_gen
  import uart_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clear,
  input  logic [DIV_W-1:0] i_div,
  output logic             o_tick
);

  localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] w_last;

  assign w_last = i_div - ONE;
  assign o_tick = (r_cnt == w_last);

  // Count clocks, wrapping on each tick or restarting on a clear request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clear || o_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + ONE;
    end
  end

endmodule

// File: rtl/uart_rx_oversample.sv
// 8N1 UART receiver, 16x oversampled, start bit validated at mid-bit.
// Presents each good byte with a one-cycle strobe and flags bad stop bits.
module uart_rx_oversample
  import uart_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       Rx,
  input  logic [2:0] BR_Select,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] MID_TICK  = 4'(OVERSAMPLE / 2 - 1);

  rx_state_t              r_state;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_rxPrev;
  logic [2:0]             r_brSel;
  logic [3:0]             r_tickCnt;
  logic [2:0]             r_bitCnt;
  logic [7:0]             r_shift;
  logic                   r_stopPend;
  logic                   r_stopBit;

  logic                   w_rxSync;
  logic                   w_startDetect;
  logic                   w_tick;
  logic [DIV_W-1:0]       w_div;

  assign w_rxSync      = r_sync[SYNC_STAGES-1];
  assign w_startDetect = (r_state == ST_IDLE) && r_rxPrev && !w_rxSync;
  assign w_div         = baud_div(r_brSel);

  baud_tick_gen u_tick (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear (w_startDetect),
    .i_div   (w_div),
    .o_tick  (w_tick)
  );

  // Bring the asynchronous line into the clock domain; idle level is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], Rx};
    end
  end

  // Frame FSM: start validation, LSB-first shift, stop check, output strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_rxPrev   <= 1'b1;
      r_brSel    <= 3'd0;
      r_tickCnt  <= 4'd0;
      r_bitCnt   <= 3'd0;
      r_shift    <= 8'h00;
      r_stopPend <= 1'b0;
      r_stopBit  <= 1'b0;
      rx_data    <= 8'h00;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      rx_busy    <= 1'b0;
    end else begin
      r_rxPrev  <= w_rxSync;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;

      if (r_stopPend) begin
        r_stopPend <= 1'b0;
        if (r_stopBit) begin
          rx_data  <= r_shift;
          rx_valid <= 1'b1;
        end else begin
          frame_err <= 1'b1;
        end
      end

      case (r_state)
        ST_IDLE: begin
          r_brSel <= BR_Select;
          if (w_startDetect) begin
            r_state   <= ST_START;
            r_tickCnt <= 4'd0;
            r_bitCnt  <= 3'd0;
            rx_busy   <= 1'b1;
          end
        end

        ST_START: begin
          if (w_tick) begin
            if (r_tickCnt == MID_TICK) begin
              r_tickCnt <= 4'd0;
              if (!w_rxSync) begin
                r_state <= ST_DATA;
              end else begin
                r_state <= ST_IDLE;
                rx_busy <= 1'b0;
              end
            end else begin
              r_tickCnt <= r_tickCnt + 4'd1;
            end
          end
        end

        ST_DATA: begin
          if (w_tick) begin
            if (r_tickCnt == LAST_TICK) begin
              r_tickCnt <= 4'd0;
              r_shift   <= {w_rxSync, r_shift[7:1]};
              r_bitCnt  <= r_bitCnt + 3'd1;
              if (r_bitCnt == 3'd7) begin
                r_state <= ST_STOP;
              end
            end else begin
              r_tickCnt <= r_tickCnt + 4'd1;
            end
          end
        end

        ST_STOP: begin
          if (w_tick) begin
            if (r_tickCnt == LAST_TICK) begin
              r_tickCnt  <= 4'd0;
              r_stopPend <= 1'b1;
              r_stopBit  <= w_rxSync;
              if (w_rxSync) begin
                r_state <= ST_IDLE;
                rx_busy <= 1'b0;
              end else begin
                r_state <= ST_WAIT_HIGH;
              end
            end else begin
              r_tickCnt <= r_tickCnt + 4'd1;
            end
          end
        end

        ST_WAIT_HIGH: begin
          if (w_rxSync) begin
            r_state <= ST_IDLE;
            rx_busy <= 1'b0;
          end
        end

        default: begin
          r_state <= ST_IDLE;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Directed bench for uart_rx_oversample: serial frames driven on Rx with
// hand-computed expected bytes, strobe counts and cycle latencies.
module tb_uart_rx_oversample;

  localparam int BIT115 = 864;   // 16 * 54 clocks
  localparam int BIT576 = 1744;  // 16 * 109 clocks

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       Rx = 1'b1;
  logic [2:0] BR_Select = 3'd7;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       rx_busy;

  int vectors = 0;
  int miscompares = 0;

  int cyc = 0;
  int validCount = 0, errCount = 0, wideCount = 0, bothCount = 0;
  int busyRiseCyc = 0, lastValidCyc = 0, prevValidCyc = 0, lastLatency = 0;
  logic [7:0] lastData = 8'h00, prevData = 8'h00;
  logic prevValid = 1'b0, prevBusy = 1'b0;

  uart_rx_oversample dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .Rx        (Rx),
    .BR_Select (BR_Select),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .rx_busy   (rx_busy)
  );

  // 100 MHz clock.
  always #5 clk = ~clk;

  // Free-running cycle count used to time strobes against start detect.
  always @(posedge clk) cyc <= cyc + 1;

  // Watch the outputs mid-cycle and log strobes, widths and latencies.
  always @(negedge clk) begin
    if (rx_valid && frame_err) bothCount++;
    if (rx_valid && prevValid) wideCount++;
    if (rx_busy && !prevBusy) busyRiseCyc = cyc;
    if (rx_valid && !prevValid) begin
      validCount++;
      prevValidCyc = lastValidCyc;
      lastValidCyc = cyc;
      lastLatency  = cyc - busyRiseCyc;
      prevData     = lastData;
      lastData     = rx_data;
    end
    if (frame_err) errCount++;
    prevValid = rx_valid;
    prevBusy  = rx_busy;
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive one 8N1 frame starting at a falling clock edge; ends on one too.
  task automatic applyStimulus(input logic [7:0] data, input logic stopBit, input int bitClks);
    Rx = 1'b0;
    repeat (bitClks) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      Rx = data[i];
      repeat (bitClks) @(negedge clk);
    end
    Rx = stopBit;
    repeat (bitClks) @(negedge clk);
  endtask

  task automatic idleClks(input int n);
    Rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Latency from start detect to strobe: 152 ticks of DIV clocks, plus one.
  initial begin
    repeat (5) @(negedge clk);
    #1;
    checkOutput("reset_data",  int'(rx_data),   0);
    checkOutput("reset_valid", int'(rx_valid),  0);
    checkOutput("reset_err",   int'(frame_err), 0);
    checkOutput("reset_busy",  int'(rx_busy),   0);
    @(negedge clk);
    rst_n = 1'b1;
    idleClks(50);

    // Good frame 0xA5 at 115200.
    applyStimulus(8'hA5, 1'b1, BIT115);
    idleClks(20);
    #1;
    checkOutput("a5_data",    int'(rx_data), 'hA5);
    checkOutput("a5_count",   validCount, 1);
    checkOutput("a5_latency", lastLatency, 152 * 54 + 1);
    checkOutput("a5_err",     errCount, 0);

    // Short low pulse rejected at the start-bit midpoint.
    @(negedge clk);
    Rx = 1'b0;
    repeat (100) @(negedge clk);
    #1;
    checkOutput("glitch_busy_hi", int'(rx_busy), 1);
    @(negedge clk);
    repeat (100) @(negedge clk);
    Rx = 1'b1;
    repeat (600) @(negedge clk);
    #1;
    checkOutput("glitch_busy_lo", int'(rx_busy), 0);
    checkOutput("glitch_count",   validCount, 1);
    checkOutput("glitch_err",     errCount, 0);
    checkOutput("glitch_data",    int'(rx_data), 'hA5);

    // 0x3C with a low stop bit held for three bit periods, then 0x11.
    @(negedge clk);
    applyStimulus(8'h3C, 1'b0, BIT115);
    repeat (2 * BIT115) @(negedge clk);
    #1;
    checkOutput("ferr_count", errCount, 1);
    checkOutput("ferr_busy",  int'(rx_busy), 1);
    checkOutput("ferr_valid", validCount, 1);
    checkOutput("ferr_data",  int'(rx_data), 'hA5);
    @(negedge clk);
    idleClks(BIT115);
    #1;
    checkOutput("ferr_release", int'(rx_busy), 0);
    @(negedge clk);
    applyStimulus(8'h11, 1'b1, BIT115);
    idleClks(20);
    #1;
    checkOutput("x11_data",  int'(rx_data), 'h11);
    checkOutput("x11_count", validCount, 2);
    checkOutput("x11_err",   errCount, 1);

    // 0x5A at 57600 with the select flipped to 115200 mid-frame.
    @(negedge clk);
    BR_Select = 3'd6;
    idleClks(20);
    fork
      applyStimulus(8'h5A, 1'b1, BIT576);
      begin
        repeat (5 * BIT576) @(negedge clk);
        BR_Select = 3'd7;
      end
    join
    idleClks(20);
    #1;
    checkOutput("x5a_data",    int'(rx_data), 'h5A);
    checkOutput("x5a_count",   validCount, 3);
    checkOutput("x5a_latency", lastLatency, 152 * 109 + 1);

    // Reset in data bit 4 of 0xFF, then 0x81 at the newly selected rate.
    @(negedge clk);
    Rx = 1'b0;
    repeat (BIT115) @(negedge clk);
    Rx = 1'b1;
    repeat (4 * BIT115 + BIT115 / 2) @(negedge clk);
    #1;
    checkOutput("rst_busy_before", int'(rx_busy), 1);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_data",  int'(rx_data),   0);
    checkOutput("rst_valid", int'(rx_valid),  0);
    checkOutput("rst_err",   int'(frame_err), 0);
    checkOutput("rst_busy",  int'(rx_busy),   0);
    @(negedge clk);
    idleClks(20);
    rst_n = 1'b1;
    idleClks(200);
    #1;
    checkOutput("rst_no_partial", validCount, 3);
    @(negedge clk);
    applyStimulus(8'h81, 1'b1, BIT115);
    idleClks(20);
    #1;
    checkOutput("x81_data",    int'(rx_data), 'h81);
    checkOutput("x81_count",   validCount, 4);
    checkOutput("x81_latency", lastLatency, 152 * 54 + 1);

    // 0x00 then 0xFF with no idle gap: strobes ten bit periods apart.
    @(negedge clk);
    applyStimulus(8'h00, 1'b1, BIT115);
    applyStimulus(8'hFF, 1'b1, BIT115);
    idleClks(20);
    #1;
    checkOutput("b2b_first",    int'(prevData), 'h00);
    checkOutput("b2b_second",   int'(lastData), 'hFF);
    checkOutput("b2b_interval", lastValidCyc - prevValidCyc, 10 * BIT115);
    checkOutput("b2b_count",    validCount, 6);
    checkOutput("b2b_err",      errCount, 1);

    checkOutput("valid_width", wideCount, 0);
    checkOutput("valid_err_overlap", bothCount, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
